// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch resolve queue feeding predictor updates
module branch_resolve_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_SIZE   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [ADDR_WIDTH-1:0]      push_pc_i,
    input  logic                       push_pred_taken_i,
    input  logic [ADDR_WIDTH-1:0]      push_pred_target_i,
    input  logic [GHR_SIZE-1:0]        push_ghr_i,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic [ADDR_WIDTH-1:0]      res_target_i,
    output logic                       upd_valid_o,
    output logic [ADDR_WIDTH-1:0]      upd_pc_o,
    output logic                       upd_taken_o,
    output logic [GHR_SIZE-1:0]        upd_ghr_o,
    output logic                       flush_o,
    output logic [ADDR_WIDTH-1:0]      redirect_pc_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [CW-1:0]           count_q;
    logic [DEPTH-1:0]        valid_q;

    logic [ADDR_WIDTH-1:0]   pc_mem     [DEPTH];
    logic                    taken_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0]   target_mem [DEPTH];
    logic [GHR_SIZE-1:0]     ghr_mem    [DEPTH];

    logic                    in_run;
    logic                    push_fire;
    logic                    keep_push;
    logic                    pop_fire;
    logic                    empty_res;
    logic                    mispredict;
    logic [ADDR_WIDTH-1:0]   head_pc;
    logic                    head_taken;
    logic [ADDR_WIDTH-1:0]   head_target;
    logic [GHR_SIZE-1:0]     head_ghr;
    logic [CW-1:0]           push_inc;
    logic [CW-1:0]           pop_dec;

    // Handshake, pop qualification and misprediction detection for the head entry
    always_comb begin
        in_run       = (state_q == RUN);
        head_pc      = pc_mem[head_q];
        head_taken   = taken_mem[head_q];
        head_target  = target_mem[head_q];
        head_ghr     = ghr_mem[head_q];
        push_ready_o = (count_q != FULL_CNT) && in_run;
        push_fire    = push_valid_i && push_ready_o;
        // A resolve during FLUSH sees an (already squashed) empty queue
        pop_fire     = res_valid_i && in_run && (count_q != '0) && valid_q[head_q];
        empty_res    = res_valid_i && !pop_fire;
        mispredict   = pop_fire &&
                       ((head_taken != res_taken_i) ||
                        (res_taken_i && (head_target != res_target_i)));
        // A push alongside a mispredicting resolve is younger and gets squashed
        keep_push    = push_fire && !mispredict;
        push_inc     = {{(CW-1){1'b0}}, keep_push};
        pop_dec      = {{(CW-1){1'b0}}, pop_fire};
        count_o      = count_q;
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (keep_push) begin
            pc_mem[tail_q]     <= push_pc_i;
            taken_mem[tail_q]  <= push_pred_taken_i;
            target_mem[tail_q] <= push_pred_target_i;
            ghr_mem[tail_q]    <= push_ghr_i;
        end
    end

    // Pointers, occupancy, FSM and registered update/flush/error outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            upd_valid_o   <= 1'b0;
            upd_pc_o      <= '0;
            upd_taken_o   <= 1'b0;
            upd_ghr_o     <= '0;
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
            err_o         <= 1'b0;
        end else begin
            upd_valid_o <= pop_fire;
            flush_o     <= mispredict;
            err_o       <= empty_res;

            if (pop_fire) begin
                upd_pc_o    <= head_pc;
                upd_taken_o <= res_taken_i;
                upd_ghr_o   <= {head_ghr[GHR_SIZE-2:0], res_taken_i};
            end

            if (mispredict) begin
                redirect_pc_o <= res_taken_i ? res_target_i
                                             : head_pc + ADDR_WIDTH'(4);
                head_q        <= '0;
                tail_q        <= '0;
                count_q       <= '0;
                valid_q       <= '0;
                state_q       <= FLUSH;
            end else begin
                // FLUSH lasts exactly one cycle, so any non-mispredict cycle lands in RUN
                state_q <= RUN;
                count_q <= count_q + push_inc - pop_dec;
                if (pop_fire) begin
                    head_q          <= head_q + PW'(1);
                    valid_q[head_q] <= 1'b0;
                end
                if (keep_push) begin
                    tail_q          <= tail_q + PW'(1);
                    valid_q[tail_q] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - randomized and directed bench for branch_resolve_queue
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_pc_i;
    logic        push_pred_taken_i;
    logic [31:0] push_pred_target_i;
    logic [3:0]  push_ghr_i;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        upd_valid_o;
    logic [31:0] upd_pc_o;
    logic        upd_taken_o;
    logic [3:0]  upd_ghr_o;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic [2:0]  count_o;
    logic        err_o;

    branch_resolve_queue #(.ADDR_WIDTH(32), .GHR_SIZE(4), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .push_valid_i       (push_valid_i),
        .push_ready_o       (push_ready_o),
        .push_pc_i          (push_pc_i),
        .push_pred_taken_i  (push_pred_taken_i),
        .push_pred_target_i (push_pred_target_i),
        .push_ghr_i         (push_ghr_i),
        .res_valid_i        (res_valid_i),
        .res_taken_i        (res_taken_i),
        .res_target_i       (res_target_i),
        .upd_valid_o        (upd_valid_o),
        .upd_pc_o           (upd_pc_o),
        .upd_taken_o        (upd_taken_o),
        .upd_ghr_o          (upd_ghr_o),
        .flush_o            (flush_o),
        .redirect_pc_o      (redirect_pc_o),
        .count_o            (count_o),
        .err_o              (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [3:0]  ghr;
    } ent_t;

    ent_t        mq[$];
    logic        m_flush;
    logic        e_upd_valid;
    logic [31:0] e_upd_pc;
    logic        e_upd_taken;
    logic [3:0]  e_upd_ghr;
    logic        e_flush;
    logic [31:0] e_redirect;
    logic        e_err;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush     = 1'b0;
        e_upd_valid = 1'b0;
        e_upd_pc    = '0;
        e_upd_taken = 1'b0;
        e_upd_ghr   = '0;
        e_flush     = 1'b0;
        e_redirect  = '0;
        e_err       = 1'b0;
    endtask

    // One clock edge of the reference behaviour, from the inputs presented at that edge
    task automatic model_step();
        logic  was_flush;
        logic  can_push;
        logic  mis;
        ent_t  e;
        ent_t  n;
        was_flush   = m_flush;
        m_flush     = 1'b0;
        e_upd_valid = 1'b0;
        e_flush     = 1'b0;
        e_err       = 1'b0;
        can_push    = push_valid_i && !was_flush && (mq.size() < DEPTH);
        if (res_valid_i && (was_flush || mq.size() == 0)) begin
            e_err = 1'b1;
        end else if (res_valid_i) begin
            e = mq.pop_front();
            e_upd_valid = 1'b1;
            e_upd_pc    = e.pc;
            e_upd_taken = res_taken_i;
            e_upd_ghr   = {e.ghr[2:0], res_taken_i};
            mis = (e.pt != res_taken_i) || (res_taken_i && (e.tgt != res_target_i));
            if (mis) begin
                e_flush    = 1'b1;
                e_redirect = res_taken_i ? res_target_i : e.pc + 32'd4;
                mq.delete();
                m_flush    = 1'b1;
                can_push   = 1'b0;
            end
        end
        if (can_push) begin
            n.pc  = push_pc_i;
            n.pt  = push_pred_taken_i;
            n.tgt = push_pred_target_i;
            n.ghr = push_ghr_i;
            mq.push_back(n);
        end
    endtask

    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptg, input logic [3:0] pg,
                       input logic rv, input logic rt, input logic [31:0] rtg);
        push_valid_i       = pv;
        push_pc_i          = ppc;
        push_pred_taken_i  = pt;
        push_pred_target_i = ptg;
        push_ghr_i         = pg;
        res_valid_i        = rv;
        res_taken_i        = rt;
        res_target_i       = rtg;
        @(posedge clk);
        model_step();
        #1;
        push_valid_i = 1'b0;
        res_valid_i  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic [3:0] g);
        cyc(1'b1, pc, pt, tgt, g, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] tgt);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, rt, tgt);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Every cycle out of reset: DUT outputs against the reference model
    always @(negedge clk) begin
        if (rst) begin
            check("push_ready", push_ready_o, (mq.size() != DEPTH) && !m_flush);
            check("count", count_o, mq.size());
            check("upd_valid", upd_valid_o, e_upd_valid);
            check("upd_pc", upd_pc_o, e_upd_pc);
            check("upd_taken", upd_taken_o, e_upd_taken);
            check("upd_ghr", upd_ghr_o, e_upd_ghr);
            check("flush", flush_o, e_flush);
            check("redirect", redirect_pc_o, e_redirect);
            check("err", err_o, e_err);
        end
    end

    initial begin
        rst                = 1'b0;
        push_valid_i       = 1'b0;
        push_pc_i          = '0;
        push_pred_taken_i  = 1'b0;
        push_pred_target_i = '0;
        push_ghr_i         = '0;
        res_valid_i        = 1'b0;
        res_taken_i        = 1'b0;
        res_target_i       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        check("rst_count", count_o, 0);
        check("rst_ready", push_ready_o, 1);
        check("rst_outs", {upd_valid_o, flush_o, err_o, upd_pc_o, redirect_pc_o}, 0);

        // Correct not-taken resolve
        push(32'h100, 1'b0, 32'h0, 4'b0101);
        resolve(1'b0, 32'h0);
        check("t1_upd_valid", upd_valid_o, 1);
        check("t1_upd_pc", upd_pc_o, 32'h100);
        check("t1_upd_ghr", upd_ghr_o, 4'b1010);
        check("t1_flush", flush_o, 0);
        check("t1_count", count_o, 0);

        // Predicted NT, actually taken
        push(32'h200, 1'b0, 32'h0, 4'b0011);
        resolve(1'b1, 32'h280);
        check("t2_upd_ghr", upd_ghr_o, 4'b0111);
        check("t2_flush", flush_o, 1);
        check("t2_redirect", redirect_pc_o, 32'h280);
        check("t2_ready_flush", push_ready_o, 0);
        push(32'h240, 1'b0, 32'h0, 4'h0);
        check("t2_count", count_o, 0);
        check("t2_flush_end", flush_o, 0);

        // Wrong target, then taken-predicted but not taken
        push(32'h300, 1'b1, 32'h340, 4'h0);
        resolve(1'b1, 32'h380);
        check("t3_flush", flush_o, 1);
        check("t3_redirect", redirect_pc_o, 32'h380);
        idle();
        push(32'h400, 1'b1, 32'h500, 4'h0);
        resolve(1'b0, 32'h0);
        check("t3b_flush", flush_o, 1);
        check("t3b_redirect", redirect_pc_o, 32'h404);
        idle();

        // Fill, stall, drain; repeated for pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= 4; k++) push(32'(k * 16), 1'b0, 32'h0, 4'(k));
            check("t4_full_count", count_o, 4);
            check("t4_full_ready", push_ready_o, 0);
            push(32'h50, 1'b0, 32'h0, 4'h0);
            check("t4_stall_count", count_o, 4);
            for (int k = 1; k <= 4; k++) begin
                resolve(1'b0, 32'h0);
                check("t4_upd_pc", upd_pc_o, 32'(k * 16));
            end
            check("t4_empty", count_o, 0);
        end

        // Mispredict with a same-cycle push; then correct resolve plus push
        push(32'h10, 1'b0, 32'h0, 4'h1);
        push(32'h20, 1'b0, 32'h0, 4'h2);
        push(32'h30, 1'b0, 32'h0, 4'h3);
        cyc(1'b1, 32'h99, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h500);
        check("t5_count_mis", count_o, 0);
        check("t5_flush", flush_o, 1);
        idle();
        check("t5_count_after", count_o, 0);
        push(32'hA0, 1'b0, 32'h0, 4'h0);
        push(32'hB0, 1'b0, 32'h0, 4'h0);
        cyc(1'b1, 32'hC0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        check("t5_count_keep", count_o, 2);
        check("t5_upd_pc", upd_pc_o, 32'hA0);
        resolve(1'b0, 32'h0);
        check("t5_drain_pc", upd_pc_o, 32'hB0);
        resolve(1'b0, 32'h0);
        check("t5_drain_pc2", upd_pc_o, 32'hC0);

        // Resolve on empty queue
        resolve(1'b1, 32'h0);
        check("t6_err", err_o, 1);
        check("t6_no_upd", upd_valid_o, 0);
        idle();
        check("t6_err_pulse", err_o, 0);

        // Asynchronous reset mid-stream
        push(32'h10, 1'b0, 32'h0, 4'h0);
        push(32'h20, 1'b0, 32'h0, 4'h0);
        push(32'h30, 1'b0, 32'h0, 4'h0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("t7_count", count_o, 0);
        check("t7_outs", {upd_valid_o, flush_o, err_o, upd_taken_o, upd_ghr_o, upd_pc_o, redirect_pc_o}, 0);
        @(posedge clk);
        #3 rst = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 9) < 6), $urandom & 32'h0000FFFC, 1'($urandom),
                32'h40 << $urandom_range(0, 1), 4'($urandom),
                ($urandom_range(0, 9) < 4), 1'($urandom), 32'h40 << $urandom_range(0, 1));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
